// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and helpers for the button conditioner
// Purpose: board-clock default cycle counts and the counter-width helper used
//          by button_channel and button_conditioner.
// Ports:   none (package).
package button_pkg;

  localparam int DEFAULT_CHANNELS      = 5;
  localparam int DEFAULT_STABLE_CYCLES = 20;
  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_REPEAT_DELAY  = 12_500_000;
  localparam int DEFAULT_REPEAT_PERIOD = 2_500_000;
  localparam int REPEAT_CNT_W          = 32;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debouncer, optional auto-repeat
// Purpose: condition a single raw asynchronous button into a clean level plus
//          one-cycle press/release strobes, and optionally periodic repeat strobes.
// Macro:   BUTTON_REPEAT_EN builds the repeat counter; otherwise repeat_strobe is 0.
// Ports:   clock          in   system clock, rising edge
//          resetn         in   asynchronous active-low reset
//          btn            in   raw asynchronous button level
//          level          out  debounced level
//          press          out  one-cycle strobe on debounced 0->1
//          release_strobe out  one-cycle strobe on debounced 1->0
//          repeat_strobe  out  one-cycle auto-repeat strobe while held
//          (release/repeat are SystemVerilog keywords, hence the _strobe names)
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_strobe,
  output logic repeat_strobe
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   cand;
  logic [CW-1:0]          cnt;
  logic                   accept;
  logic                   press_nxt;
  logic                   release_nxt;

  assign s = sync[SYNC_STAGES-1];

  // A level change is accepted only after the candidate has been stable for
  // the whole window and differs from the current level.
  always_comb begin
    accept      = 1'b0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if ((s == cand) && (cnt == CNT_MAX) && (level != cand)) begin
      accept      = 1'b1;
      press_nxt   = cand;
      release_nxt = ~cand;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync           <= '0;
      cand           <= 1'b0;
      cnt            <= '0;
      level          <= 1'b0;
      press          <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      sync           <= {sync[SYNC_STAGES-2:0], btn};
      press          <= press_nxt;
      release_strobe <= release_nxt;
      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt == CNT_MAX) begin
        // cnt saturates here until the next toggle of s
        if (accept) level <= cand;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_REPEAT_EN
  logic [REPEAT_CNT_W-1:0] rcnt;

  // Press reloads the initial delay; release or an idle level parks the
  // counter at 0 so no repeat can coincide with press or release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rcnt          <= '0;
      repeat_strobe <= 1'b0;
    end else begin
      repeat_strobe <= 1'b0;
      if (press_nxt) begin
        rcnt <= REPEAT_CNT_W'(REPEAT_DELAY - 1);
      end else if (release_nxt || !level) begin
        rcnt <= '0;
      end else if (rcnt == '0) begin
        repeat_strobe <= 1'b1;
        rcnt          <= REPEAT_CNT_W'(REPEAT_PERIOD - 1);
      end else begin
        rcnt <= rcnt - 1'b1;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign repeat_strobe     = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel push-button conditioner top
// Purpose: one independent button_channel per raw button; outputs are the
//          per-channel results concatenated, bit i = channel i.
// Macro:   BUTTON_REPEAT_EN enables the auto-repeat strobes.
// Ports:   clock          in   system clock, rising edge
//          resetn         in   asynchronous active-low reset
//          btn_in         in   [CHANNELS] raw asynchronous button levels
//          level          out  [CHANNELS] debounced levels
//          press          out  [CHANNELS] one-cycle strobes on 0->1
//          release_strobe out  [CHANNELS] one-cycle strobes on 1->0
//          repeat_strobe  out  [CHANNELS] one-cycle auto-repeat strobes
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS      = DEFAULT_CHANNELS,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_strobe,
  output logic [CHANNELS-1:0] repeat_strobe
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clock         (clock),
      .resetn        (resetn),
      .btn           (btn_in[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_strobe(release_strobe[i]),
      .repeat_strobe (repeat_strobe[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

`ifdef BUTTON_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] btn_in = '0;
  logic [4:0] level, press, release_strobe, repeat_strobe;

  int total = 0;
  int bad   = 0;
  int pc [5];
  int rc [5];
  int tc [5];
  int snap_p, snap_r, snap_t;

  button_conditioner #(
    .CHANNELS     (5),
    .STABLE_CYCLES(20),
    .SYNC_STAGES  (2),
    .REPEAT_DELAY (50),
    .REPEAT_PERIOD(10)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .btn_in        (btn_in),
    .level         (level),
    .press         (press),
    .release_strobe(release_strobe),
    .repeat_strobe (repeat_strobe)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 5; i++) begin
      pc[i] = 0; rc[i] = 0; tc[i] = 0;
    end
  end

  // Strobe event counters, sampled on the inactive edge.
  always @(negedge clock) begin
    for (int i = 0; i < 5; i++) begin
      pc[i] += int'(press[i]);
      rc[i] += int'(release_strobe[i]);
      tc[i] += int'(repeat_strobe[i]);
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_level",   32'(level), 32'h0);
    chk("rst_press",   32'(press), 32'h0);
    chk("rst_release", 32'(release_strobe), 32'h0);
    chk("rst_repeat",  32'(repeat_strobe), 32'h0);
    resetn = 1'b1;
    step(5);

    // Clean press on ch0: visible on the 23rd edge after the input changes
    btn_in[0] = 1'b1;
    step(22);
    chk("p0_before_level", 32'(level), 32'h0);
    chk("p0_before_press", 32'(press), 32'h0);
    step(1);
    chk("p0_level", 32'(level), 32'h01);
    chk("p0_press", 32'(press), 32'h01);
    step(1);
    chk("p0_press_off", 32'(press), 32'h0);
    chk("p0_level_hold", 32'(level), 32'h01);

    // Glitch on ch2: 19 samples high never reaches the window
    snap_p = pc[2]; snap_r = rc[2];
    btn_in[2] = 1'b1;
    step(19);
    btn_in[2] = 1'b0;
    step(40);
    chk("glitch_level2", 32'(level[2]), 32'h0);
    chk("glitch_press2", 32'(pc[2] - snap_p), 32'h0);
    chk("glitch_rel2",   32'(rc[2] - snap_r), 32'h0);

    // Bounce on ch1: 20 segments of 5 cycles, then settle high
    snap_p = pc[1]; snap_r = rc[1];
    for (int seg = 0; seg < 20; seg++) begin
      btn_in[1] = (seg % 2 == 0);
      step(5);
    end
    btn_in[1] = 1'b1;
    step(22);
    chk("bounce_before", 32'(level[1]), 32'h0);
    step(1);
    chk("bounce_level", 32'(level), 32'h03);
    chk("bounce_press", 32'(press), 32'h02);
    step(2);
    chk("bounce_npress", 32'(pc[1] - snap_p), 32'h1);
    chk("bounce_nrel",   32'(rc[1] - snap_r), 32'h0);

    // Auto-repeat on ch3 (expected all-zero when the feature is not built)
    snap_t = tc[3];
    btn_in[3] = 1'b1;
    step(23);
    chk("rpt_press", 32'(press), 32'h08);
    step(49);
    chk("rpt_49", 32'(repeat_strobe), 32'h0);
    step(1);
    chk("rpt_50", 32'(repeat_strobe), RPT ? 32'h08 : 32'h0);
    step(9);
    chk("rpt_59", 32'(repeat_strobe), 32'h0);
    step(1);
    chk("rpt_60", 32'(repeat_strobe), RPT ? 32'h08 : 32'h0);
    step(10);
    chk("rpt_70", 32'(repeat_strobe), RPT ? 32'h08 : 32'h0);
    btn_in[3] = 1'b0;
    step(22);
    chk("rpt_rel_before", 32'(level[3]), 32'h1);
    step(1);
    chk("rpt_rel", 32'(release_strobe), 32'h08);
    chk("rpt_rel_norpt", 32'(repeat_strobe), 32'h0);
    step(40);
    chk("rpt_count", 32'(tc[3] - snap_t), RPT ? 32'd5 : 32'd0);

    // Release on ch0
    snap_r = rc[0];
    btn_in[0] = 1'b0;
    step(22);
    chk("r0_before", 32'(level[0]), 32'h1);
    step(1);
    chk("r0_release", 32'(release_strobe), 32'h01);
    chk("r0_level", 32'(level), 32'h02);
    step(1);
    chk("r0_release_off", 32'(release_strobe), 32'h0);
    chk("r0_nrel", 32'(rc[0] - snap_r), 32'h1);

    // Reset while ch4 (and ch1) held high
    btn_in[4] = 1'b1;
    step(23);
    chk("ch4_press", 32'(press), 32'h10);
    step(5);
    snap_r = rc[1] + rc[4];
    snap_p = pc[1] + pc[4];
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_level",   32'(level), 32'h0);
    chk("arst_press",   32'(press), 32'h0);
    chk("arst_release", 32'(release_strobe), 32'h0);
    chk("arst_repeat",  32'(repeat_strobe), 32'h0);
    step(3);
    resetn = 1'b1;
    step(22);
    chk("post_rst_before", 32'(level), 32'h0);
    step(1);
    chk("post_rst_level", 32'(level), 32'h12);
    chk("post_rst_press", 32'(press), 32'h12);
    step(1);
    chk("post_rst_press_off", 32'(press), 32'h0);
    chk("post_rst_no_rel", 32'(rc[1] + rc[4] - snap_r), 32'h0);
    chk("post_rst_npress", 32'(pc[1] + pc[4] - snap_p), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel input conditioner for the board push-buttons feeding the game controller. Each raw asynchronous button is synchronised, debounced against a parametrised stability window, and presented as a clean level plus one-cycle press/release strobes. An optional auto-repeat generator emits periodic strobes while a button is held, for continuous piece movement.

## Interface
- `CHANNELS`, 5: number of independent button channels, ≥1.
- `STABLE_CYCLES`, 20: consecutive identical synchronised samples required to accept a new level, ≥2.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `REPEAT_DELAY`, 12_500_000: cycles from press strobe to first repeat strobe, ≥1; only used with `BUTTON_REPEAT_EN`.
- `REPEAT_PERIOD`, 2_500_000: cycles between later repeat strobes, ≥1; only used with `BUTTON_REPEAT_EN`.
- `clock`  in  1  single system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `btn_in`  in  CHANNELS  raw asynchronous button levels, bit i = channel i.
- `level`  out  CHANNELS  debounced level.
- `press`  out  CHANNELS  one-cycle strobe on debounced 0→1.
- `release`  out  CHANNELS  one-cycle strobe on debounced 1→0.
- `repeat`  out  CHANNELS  one-cycle auto-repeat strobe; constant 0 when `BUTTON_REPEAT_EN` is undefined.

## Operation
- Channels are fully independent; no cross-channel state.
- Per channel: synchroniser chain, last stage = `s`; candidate register `cand`; stability counter `cnt` of width $clog2(STABLE_CYCLES).
- Each cycle: if `s != cand` then `cand <= s`, `cnt <= 0`. Else if `cnt == STABLE_CYCLES-1`: when `level != cand`, `level <= cand` and the matching strobe (`press` if cand=1, `release` if cand=0) asserts for that one cycle; `cnt` holds (saturates). Else `cnt <= cnt+1`.
- Any toggle of `s` restarts the window; a glitch of any length shorter than the window never changes `level`.
- All outputs registered; strobes assert in the same cycle `level` changes, deassert next cycle unless a new event occurs.
- Auto-repeat (macro on): per-channel down-counter `rcnt`, 32-bit max. On press strobe cycle, `rcnt <= REPEAT_DELAY-1`. While `level`=1 and no release: if `rcnt == 0`, `repeat` strobes and `rcnt <= REPEAT_PERIOD-1`; else decrement. On release or while `level`=0, `rcnt` holds 0 and `repeat` stays 0; `repeat` never coincides with `press` or `release`.

## Timing
- Reset (`resetn`=0, asynchronous): sync flops, `cand`, `cnt`, `rcnt`, `level`, `press`, `release`, `repeat` all 0.
- Latency: input edge stable from cycle t → `level`/strobe change at cycle t + SYNC_STAGES + STABLE_CYCLES + 1 (23 with defaults).
- First `repeat` exactly REPEAT_DELAY cycles after the `press` cycle, then every REPEAT_PERIOD cycles.
- Button held through reset release: treated as a new press; `press` strobes after the full latency from reset deassertion.
- Reset asserted mid-window or mid-repeat: all state cleared immediately; no strobe is emitted on reset or on its release.
- Simultaneous events on several channels are all reported in the same cycle.

## Configuration
- `BUTTON_REPEAT_EN` defined: repeat counters built; `repeat` behaves as above.
- Undefined: no repeat logic synthesised; `repeat` tied to 0; REPEAT_* parameters ignored.

## Structure
- Shared package `button_pkg`: counter-width helper function, default constants for stable/repeat cycle counts at the board clock.
- Sub-module `button_channel`: one channel (sync + debounce + optional repeat); top generates `CHANNELS` instances and concatenates outputs.

## Test plan
- Clean press, ch0 held high from cycle 10 (defaults) → `level[0]`=1 and `press[0]` one-cycle pulse at cycle 33; other channels stay 0.
- Bounce: ch1 toggles every 5 cycles for 100 cycles then settles high → exactly one `press[1]`, 23 cycles after final edge; no `release[1]`.
- Glitch: ch2 high for 19 cycles then low → `level[2]` stays 0, no strobes.
- Release: ch0 held low after press → one `release[0]` 23 cycles after falling edge.
- Repeat (macro on, REPEAT_DELAY=50, REPEAT_PERIOD=10): hold ch3 → `repeat[3]` at press+50, +60, +70; release → no further repeats.
- Reset: assert `resetn`=0 while ch4 held and `level[4]`=1 → all outputs 0 immediately; after release `press[4]` reappears 23 cycles later.
